// File: rtl/hs_rx_array_if.sv
// hs_rx_array_if -- port bundle for hs_rx_array.
//   slave  : the receiver array (hs_rx_array itself)
//   master : whoever drives the senders and the FIFO consumer
//
// Handshake semantics:
//   * Sender side, per channel i, is 4-phase req/ack.
//     - The sender may raise req[i] only while enableTx[i]=1.
//     - It keeps data[i] stable until ack[i]=1, then drops req[i].
//     - ack[i] falls after req[i] is seen low.
//   * Consumer side is valid/ready.
//     - A word transfers on a rising edge where outputValid=1 and outputReady=1.
//     - While outputValid=1 and outputReady=0, outputData and outputChan hold.
//     - outputValid never depends on outputReady.
// chanState is a debug view of every channel FSM (2 bits per channel).
interface hs_rx_array_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4
) ();
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic [CHANNELS-1:0]        req;
    logic [CHANNELS*DATA_W-1:0] data;
    logic [CHANNELS-1:0]        enableTx;
    logic [CHANNELS-1:0]        ack;
    logic [DATA_W-1:0]          outputData;
    logic [CHAN_W-1:0]          outputChan;
    logic                       outputValid;
    logic                       outputReady;
    logic [CNT_W-1:0]           fifoCount;
    logic [2*CHANNELS-1:0]      chanState;

    modport slave (
        input  req, data, outputReady,
        output enableTx, ack, outputData, outputChan, outputValid, fifoCount, chanState
    );

    modport master (
        output req, data, outputReady,
        input  enableTx, ack, outputData, outputChan, outputValid, fifoCount, chanState
    );
endinterface

// File: rtl/hs_rx_array.sv
// hs_rx_array -- array of CHANNELS independent 4-phase req/ack receivers.
//
// Accepted words go into one shared FIFO, tagged with their channel index.
// A round-robin arbiter allows at most one capture per cycle.
// A full FIFO stalls requesting channels in WAIT_REQ; it never drops a word.
//
// Optional feature: define HS_RX_REQ_SYNC_EN to pass every req bit through a
// 2-flop synchronizer. This adds 2 cycles of req-to-state latency.
// When it is undefined, req must be synchronous to clk and is used directly.
module hs_rx_array #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4
) (
    input  logic         clk,
    input  logic         reset,     // asynchronous, active low
    hs_rx_array_if.slave bus
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_REQ = 2'd1,
        ST_ACK      = 2'd2
    } ch_state_e;

    // ---------------------------------------------------------------
    // Effective request (optionally synchronized)
    // ---------------------------------------------------------------
    logic [CHANNELS-1:0] req_e;

`ifdef HS_RX_REQ_SYNC_EN
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    // Two-flop synchronizer on every req bit; req_e is the second stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.req;
            sync2_q <= sync1_q;
        end
    end

    assign req_e = sync2_q;
`else
    assign req_e = bus.req;
`endif

    // ---------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------
    ch_state_e           state_q [CHANNELS];
    ch_state_e           state_d [CHANNELS];
    logic [CHANNELS-1:0] enable_q, enable_d;
    logic [CHANNELS-1:0] ack_q, ack_d;
    logic [CHANNELS-1:0] cap_req;
    logic [CHANNELS-1:0] grant_oh;
    logic                grant_vld;
    logic [CHAN_W-1:0]   grant_idx;
    logic [CHAN_W-1:0]   rr_q, rr_d;

    logic [DATA_W-1:0]   mem_data_q [DEPTH];
    logic [CHAN_W-1:0]   mem_chan_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fifo_valid;
    logic                pop;
    logic                push;
    logic                can_push;
    logic [DATA_W-1:0]   wr_data;

    // ---------------------------------------------------------------
    // FIFO flow control
    // ---------------------------------------------------------------
    // A full FIFO can still take a word on an edge where it also pops.
    assign fifo_valid = (cnt_q != '0);
    assign pop        = fifo_valid && bus.outputReady;
    assign can_push   = (cnt_q < CNT_W'(DEPTH)) || pop;
    assign push       = grant_vld;

    // Capture requests: a channel in WAIT_REQ with its req_e asserted.
    always_comb begin
        cap_req = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cap_req[i] = (state_q[i] == ST_WAIT_REQ) && req_e[i];
        end
    end

    // Round-robin arbiter: the grant goes to the first requester at or after rr_q, wrapping.
    always_comb begin : arb
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        idx       = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!grant_vld && cap_req[idx] && can_push) begin
                grant_vld = 1'b1;
                grant_idx = CHAN_W'(idx);
            end
        end
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Pointer advances past the granted channel so it has lowest priority next time.
    always_comb begin
        rr_d = rr_q;
        if (grant_vld) begin
            rr_d = (grant_idx == CHAN_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Per-channel FSMs
    // ---------------------------------------------------------------
    // Next state and registered-output values for every channel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]  = state_q[i];
            enable_d[i] = 1'b0;
            ack_d[i]    = 1'b0;
            case (state_q[i])
                ST_IDLE: begin
                    if (!req_e[i]) begin
                        state_d[i] = ST_WAIT_REQ;
                    end
                end
                ST_WAIT_REQ: begin
                    if (grant_oh[i]) begin
                        state_d[i] = ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!req_e[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
            // enableTx tracks WAIT_REQ exactly.
            enable_d[i] = (state_d[i] == ST_WAIT_REQ);
            // ack rises one edge after the grant and drops on the edge that leaves ACK.
            ack_d[i]    = (state_q[i] == ST_ACK) && (state_d[i] == ST_ACK);
        end
    end

    // Channel state, output registers and the round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
            end
            enable_q <= '0;
            ack_q    <= '0;
            rr_q     <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
            end
            enable_q <= enable_d;
            ack_q    <= ack_d;
            rr_q     <= rr_d;
        end
    end

    // ---------------------------------------------------------------
    // Shared FIFO
    // ---------------------------------------------------------------
    assign wr_data = bus.data[int'(grant_idx)*DATA_W +: DATA_W];

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO pointers and occupancy; reset discards every buffered word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; its contents are only visible through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= wr_data;
            mem_chan_q[wr_ptr_q] <= grant_idx;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.enableTx    = enable_q;
    assign bus.ack         = ack_q;
    assign bus.outputValid = fifo_valid;
    assign bus.outputData  = fifo_valid ? mem_data_q[rd_ptr_q] : '0;
    assign bus.outputChan  = fifo_valid ? mem_chan_q[rd_ptr_q] : '0;
    assign bus.fifoCount   = cnt_q;

    // Debug view of the channel FSMs, 2 bits per channel.
    always_comb begin
        bus.chanState = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.chanState[2*i +: 2] = state_q[i];
        end
    end
endmodule
